// File: rtl/fancy_sample_fifo.sv
// Sample FIFO behind fancy_counter: buffers {data, fancy} pairs and hands them out on valid/ready.
// The counter cannot be stalled, so samples that arrive while the buffer is full are dropped and counted.
module fancy_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [WIDTH-1:0]           in_fancy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  output logic [15:0]                drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count_q;
  logic               overflow_q;
  logic [15:0]        drop_q;

  logic push;
  logic pop;
  logic drop;

  // Flags come only from the count register, so they never glitch with the inputs.
  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign out_valid = !empty;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign drop_count = drop_q;

  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  assign out_data = empty ? '0 : mem[rd_ptr];

  // Storage is never reset; stale entries are hidden by the empty mask.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= {in_data, in_fancy};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 16'hFFFF) begin
          drop_q <= drop_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fancy_sample_fifo.sv
// Self-checking bench for fancy_sample_fifo: a queue-based scoreboard with its own occupancy model,
// checked before every clock edge, plus targeted checks for fill, drop, reset, saturation and integration.
module tb_fancy_sample_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic [WIDTH-1:0]  in_fancy;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH-1:0] out_data;
  logic [$clog2(DEPTH):0] count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic [15:0]       drop_count;

  always #5 clk = ~clk;

  fancy_sample_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_fancy   (in_fancy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  bit          model_known = 1'b0;
  bit          m_overflow = 1'b0;
  int unsigned m_drops = 0;
  int unsigned pop_count = 0;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, check the pre-edge state against the model,
  // then advance the model to what the coming rising edge should produce.
  task automatic applyStimulus(input logic rst, input logic v, input logic [15:0] d,
                               input logic [15:0] f, input logic rdy);
    bit m_pop;
    bit m_push;
    int sz;
    @(negedge clk);
    reset     = rst;
    in_valid  = v;
    in_data   = d;
    in_fancy  = f;
    out_ready = rdy;
    #1;
    sz = exp_q.size();
    if (model_known) begin
      checkOutput("count", 32'(count), 32'(sz));
      checkOutput("full", 32'(full), 32'(sz == DEPTH));
      checkOutput("empty", 32'(empty), 32'(sz == 0));
      checkOutput("out_valid", 32'(out_valid), 32'(sz > 0));
      checkOutput("out_data", out_data, (sz > 0) ? exp_q[0] : 32'h0);
      checkOutput("overflow", 32'(overflow), 32'(m_overflow));
      checkOutput("drop_count", 32'(drop_count), m_drops);
    end
    m_pop  = (sz > 0) && rdy;
    m_push = v && ((sz < DEPTH) || m_pop);
    if (rst) begin
      exp_q.delete();
      m_overflow  = 1'b0;
      m_drops     = 0;
      model_known = 1'b1;
    end else begin
      if (m_pop) begin
        void'(exp_q.pop_front());
        pop_count++;
      end
      if (m_push) begin
        exp_q.push_back({d, f});
      end else if (v) begin
        m_overflow = 1'b1;
        if (m_drops < 32'hFFFF) m_drops++;
      end
    end
  endtask

  function automatic logic [15:0] fancyRef(input logic [15:0] c);
    logic [15:0] sq;
    sq = c * c;
    return sq ^ 16'h5A5A;
  endfunction

  logic [15:0] cnt;
  int unsigned enabled;
  bit          en;
  bit          rdy;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_fancy = '0; out_ready = 1'b0;
    applyStimulus(1, 0, 0, 0, 0);

    // Fill
    for (int k = 0; k < 8; k++) applyStimulus(0, 1, 16'(k), 16'(100 + k), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("fill_count", 32'(count), 32'd8);
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_head", out_data, {16'd0, 16'd100});
    checkOutput("fill_overflow", 32'(overflow), 32'd0);

    // Drop, then drain
    for (int k = 8; k < 11; k++) applyStimulus(0, 1, 16'(k), 16'(100 + k), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("drop_count3", 32'(drop_count), 32'd3);
    checkOutput("drop_overflow", 32'(overflow), 32'd1);
    checkOutput("drop_full", 32'(count), 32'd8);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(0, 0, 0, 0, 0);
      checkOutput("drain_order", out_data, {16'(k), 16'(100 + k)});
      applyStimulus(0, 0, 0, 0, 1);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_data0", out_data, 32'h0);

    // Full push+pop
    for (int k = 0; k < 8; k++) applyStimulus(0, 1, 16'(200 + k), 16'(k), 0);
    for (int k = 8; k < 28; k++) applyStimulus(0, 1, 16'(200 + k), 16'(k), 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pp_count", 32'(count), 32'd8);
    checkOutput("pp_drops", 32'(drop_count), 32'd3);
    checkOutput("pp_head", out_data, {16'd220, 16'd20});

    // Reset mid-stream with 5 buffered
    for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(1, 1, 16'hDEAD, 16'hBEEF, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_drops", 32'(drop_count), 32'd0);
    applyStimulus(0, 1, 16'd7, 16'd7, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rst_first", out_data, {16'd7, 16'd7});

    // Saturation
    for (int k = 0; k < 7; k++) applyStimulus(0, 1, 16'(k), 16'(k), 0);
    for (int k = 0; k < 65540; k++) applyStimulus(0, 1, 16'(k), 16'hFFFF, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("sat_drops", 32'(drop_count), 32'hFFFF);
    checkOutput("sat_overflow", 32'(overflow), 32'd1);

    // Integration with a reference counter model
    applyStimulus(1, 0, 0, 0, 0);
    cnt = '0; enabled = 0; pop_count = 0;
    for (int k = 0; k < 600; k++) begin
      en  = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 1) == 1);
      applyStimulus(0, en, cnt, fancyRef(cnt), rdy);
      if (en) begin
        enabled++;
        cnt = cnt + 16'd1;
      end
    end
    for (int k = 0; k < DEPTH + 2; k++) begin
      if (exp_q.size() > 0) applyStimulus(0, 0, 0, 0, 1);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("integ_empty", 32'(empty), 32'd1);
    checkOutput("integ_balance", pop_count + 32'(drop_count), enabled);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
